// File: rtl/sio_pkg.sv
// Shared types and helpers for the SingleChannelIO word initiator.
// Access sizes, FSM states and the byte-count decode live here.
package sio_pkg;

    localparam int unsigned SIO_DATA_W = 64;
    localparam int unsigned SIO_BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } sio_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } sio_init_state_e;

    function automatic logic [3:0] sio_bytes(sio_size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/sio_word_initiator_if.sv
// Core-side request/response bundle and the SingleChannelIO byte bus.
// Initiator takes the slave side of the core bundle and the master side of the bus.
interface sio_core_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_size,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata,
        input  rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata,
        output rsp_error
    );
endinterface

interface sio_bus_if #(
    parameter int ADDR_W = 64
);
    logic              taskValid;
    logic              rwCtrl;
    logic [ADDR_W-1:0] address;
    logic [7:0]        writeBus;
    logic              taskReady;
    logic              taskError;
    logic [7:0]        readBus;

    modport master (
        output taskValid, rwCtrl, address, writeBus,
        input  taskReady, taskError, readBus
    );

    modport slave (
        input  taskValid, rwCtrl, address, writeBus,
        output taskReady, taskError, readBus
    );
endinterface

// File: rtl/sio_word_initiator.sv
// Runs one 1/2/4/8-byte load/store as a little-endian burst of
// single-byte SingleChannelIO transactions and returns one response.
module sio_word_initiator
    import sio_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16
) (
    input logic     clk,
    input logic     rst,
    sio_core_if.slave core,
    sio_bus_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    sio_init_state_e   state_q, state_d;
    logic              write_q, write_d;
    logic [3:0]        n_q, n_d;
    logic [2:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       acc_q, acc_d;
    logic              err_q, err_d;
    logic [CW-1:0]     wait_q, wait_d;

    logic last_byte;
    logic expired;

    assign last_byte = ({1'b0, idx_q} == (n_q - 4'd1));
    assign expired   = (wait_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            n_q     <= 4'd1;
            idx_q   <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        n_d     = n_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        err_d   = err_q;
        wait_d  = wait_q;

        unique case (state_q)
            IDLE: begin
                if (core.req_valid) begin
                    write_d = core.req_write;
                    n_d     = sio_bytes(sio_size_e'(core.req_size));
                    idx_d   = 3'd0;
                    addr_d  = core.req_addr;
                    wdata_d = core.req_wdata;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    wait_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.taskReady) begin
                    wait_d = '0;
                    if (bus.taskError) begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        state_d = RESP;
                    end else begin
                        if (!write_q) begin
                            acc_d[{idx_q, 3'b000} +: 8] = bus.readBus;
                        end
                        if (last_byte) begin
                            state_d = RESP;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            addr_d  = addr_q + 1'b1;
                            wdata_d = wdata_q >> 8;
                        end
                    end
                end else if (expired) begin
                    // transfer beats expiry when both land on the same edge
                    err_d   = 1'b1;
                    acc_d   = '0;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                if (core.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign core.req_ready = (state_q == IDLE);
    assign core.rsp_valid = (state_q == RESP);
    assign core.rsp_rdata = core.rsp_valid ? acc_q : '0;
    assign core.rsp_error = core.rsp_valid & err_q;

    assign bus.taskValid = (state_q == ISSUE);
    assign bus.rwCtrl    = write_q;
    assign bus.address   = addr_q;
    assign bus.writeBus  = wdata_q[7:0];

    a_bus_stable: assert property (
        @(posedge clk) disable iff (rst)
        (bus.taskValid && !bus.taskReady) |=>
        ($stable(bus.address) && $stable(bus.rwCtrl)
         && $stable(bus.writeBus))
    );

    a_rsp_hold: assert property (
        @(posedge clk) disable iff (rst)
        (core.rsp_valid && !core.rsp_ready) |=>
        (core.rsp_valid && $stable(core.rsp_rdata)
         && $stable(core.rsp_error))
    );

    a_exclusive: assert property (
        @(posedge clk) disable iff (rst)
        !(bus.taskValid && core.rsp_valid)
    );

endmodule

// File: tb/tb_sio_word_initiator.sv
// Scoreboard bench: 1 MiB SingleChannelIO memory responder with stall
// injection; expected responses queued at issue, checked by a monitor.
module tb_sio_word_initiator;
    import sio_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sio_core_if #(.ADDR_W(64)) core ();
    sio_bus_if  #(.ADDR_W(64)) bus ();

    sio_word_initiator #(
        .ADDR_W (64),
        .TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .core(core),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // responder
    bit [7:0] mem [0:1048575];
    int stall_n = 0;
    int scnt = 0;
    int tv_cyc = 0;
    int trans = 0;
    int writes = 0;

    assign bus.taskReady = bus.taskValid && (scnt >= stall_n);
    assign bus.taskError = bus.taskValid &&
                           (bus.address >= 64'h100000);
    assign bus.readBus   = bus.taskError ? 8'h00 :
                           mem[bus.address[19:0]];

    always @(posedge clk) begin
        scnt <= (bus.taskValid && !bus.taskReady) ? scnt + 1 : 0;
    end

    always @(posedge clk) begin
        if (bus.taskValid) tv_cyc++;
        if (bus.taskValid && bus.taskReady) begin
            trans++;
            if (bus.rwCtrl && !bus.taskError) begin
                mem[bus.address[19:0]] = bus.writeBus;
                writes++;
            end
        end
    end

    // bus must hold still while a byte is stalled
    logic        hold_chk = 1'b0;
    logic [63:0] hold_addr = '0;
    logic        hold_rw = 1'b0;
    always @(posedge clk) begin
        hold_chk  <= bus.taskValid && !bus.taskReady;
        hold_addr <= bus.address;
        hold_rw   <= bus.rwCtrl;
    end
    always @(negedge clk) begin
        if (hold_chk && bus.taskValid) begin
            check("stall_addr", bus.address, hold_addr);
            check("stall_rw", 64'(bus.rwCtrl), 64'(hold_rw));
        end
    end

    // scoreboard monitor
    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t exq[$];
    int rsp_count = 0;
    int rise_cyc = 0;
    logic rv_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (core.rsp_valid && !rv_prev) rise_cyc = cyc;
        rv_prev = core.rsp_valid;
        if (core.rsp_valid && core.rsp_ready) begin
            if (exq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got %h expected none",
                         core.rsp_rdata);
            end else begin
                e = exq.pop_front();
                check("rsp_rdata", core.rsp_rdata, e.rdata);
                check("rsp_error", 64'(core.rsp_error), 64'(e.err));
            end
            rsp_count++;
        end
    end

    task automatic expect_rsp(input logic [63:0] d, input logic er);
        exp_t e;
        e.rdata = d;
        e.err   = er;
        exq.push_back(e);
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic [63:0] a,
                          input logic [63:0] wd,
                          output int acc);
        bit ok = 0;
        @(negedge clk);
        core.req_write = w;
        core.req_size  = sz;
        core.req_addr  = a;
        core.req_wdata = wd;
        core.req_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (core.req_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        acc = cyc;
        core.req_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
    endtask

    task automatic wait_rsp(input int target);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (rsp_count >= target) ok = 1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: got %0d expected %0d",
                     rsp_count, target);
        end
    endtask

    initial begin
        int a0, a1, a2;
        int base;
        bit ok;

        core.req_valid = 1'b0;
        core.req_write = 1'b0;
        core.req_size  = 2'd0;
        core.req_addr  = '0;
        core.req_wdata = '0;
        core.rsp_ready = 1'b1;

        #2;
        check("rst_req_ready", 64'(core.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(core.rsp_valid), 64'd0);
        check("rst_rsp_error", 64'(core.rsp_error), 64'd0);
        check("rst_rsp_rdata", core.rsp_rdata, 64'd0);
        check("rst_taskValid", 64'(bus.taskValid), 64'd0);
        check("rst_rwCtrl", 64'(bus.rwCtrl), 64'd0);
        check("rst_address", bus.address, 64'd0);
        check("rst_writeBus", 64'(bus.writeBus), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: 8B load, zero-wait
        for (int i = 0; i < 8; i++) mem[32'h100 + i] = 8'(i + 1);
        tv_cyc = 0;
        expect_rsp(64'h0807060504030201, 1'b0);
        do_req(1'b0, 2'd3, 64'h100, 64'h0, a0);
        wait_rsp(1);
        check("t1_latency", 64'(rise_cyc - a0), 64'd8);
        check("t1_tv_cycles", 64'(tv_cyc), 64'd8);

        // 2: 2B store
        mem[32'h22] = 8'h5A;
        writes = 0;
        expect_rsp(64'h0, 1'b0);
        do_req(1'b1, 2'd1, 64'h20, 64'hBEEF, a0);
        wait_rsp(2);
        check("t2_mem20", 64'(mem[32'h20]), 64'hEF);
        check("t2_mem21", 64'(mem[32'h21]), 64'hBE);
        check("t2_writes", 64'(writes), 64'd2);
        check("t2_mem22", 64'(mem[32'h22]), 64'h5A);

        // 3: 4B load running off the end of memory
        mem[32'hFFFFE] = 8'h11;
        mem[32'hFFFFF] = 8'h22;
        trans = 0;
        expect_rsp(64'h0, 1'b1);
        do_req(1'b0, 2'd2, 64'hFFFFE, 64'h0, a0);
        wait_rsp(3);
        check("t3_trans", 64'(trans), 64'd3);

        // 4a: 3-cycle stall per byte
        for (int i = 0; i < 4; i++) mem[32'h40 + i] = 8'(8'hA0 + i);
        stall_n = 3;
        expect_rsp(64'hA3A2A1A0, 1'b0);
        do_req(1'b0, 2'd2, 64'h40, 64'h0, a0);
        wait_rsp(4);

        // 4b: stall beyond timeout
        stall_n = 100;
        trans = 0;
        expect_rsp(64'h0, 1'b1);
        do_req(1'b0, 2'd2, 64'h40, 64'h0, a0);
        wait_rsp(5);
        check("t4_tv_dropped", 64'(bus.taskValid), 64'd0);
        check("t4_trans", 64'(trans), 64'd0);
        stall_n = 0;

        // 5: response backpressure
        @(posedge clk);
        #1 core.rsp_ready = 1'b0;
        expect_rsp(64'h01, 1'b0);
        do_req(1'b0, 2'd0, 64'h100, 64'h0, a0);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (core.rsp_valid) ok = 1;
        end
        check("t5_rsp_seen", 64'(ok), 64'd1);
        tv_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(core.rsp_valid), 64'd1);
            check("t5_hold_rdata", core.rsp_rdata, 64'h01);
            check("t5_req_ready", 64'(core.req_ready), 64'd0);
        end
        check("t5_no_bus", 64'(tv_cyc), 64'd0);
        @(posedge clk);
        #1 core.rsp_ready = 1'b1;
        wait_rsp(6);

        // 5b: back-to-back 1B loads
        expect_rsp(64'h01, 1'b0);
        expect_rsp(64'h02, 1'b0);
        expect_rsp(64'h03, 1'b0);
        do_req(1'b0, 2'd0, 64'h100, 64'h0, a0);
        do_req(1'b0, 2'd0, 64'h101, 64'h0, a1);
        do_req(1'b0, 2'd0, 64'h102, 64'h0, a2);
        wait_rsp(9);
        check("t5_space01", 64'(a1 - a0), 64'd3);
        check("t5_space12", 64'(a2 - a1), 64'd3);

        // 6: reset in the middle of an 8B store
        base = rsp_count;
        writes = 0;
        do_req(1'b1, 2'd3, 64'h200, 64'h8877665544332211, a0);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (writes == 3) ok = 1;
        end
        check("t6_three_writes", 64'(ok), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_async_tv", 64'(bus.taskValid), 64'd0);
        check("t6_async_rsp", 64'(core.rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_writes", 64'(writes), 64'd3);
        check("t6_mem202", 64'(mem[32'h202]), 64'h33);
        check("t6_mem203", 64'(mem[32'h203]), 64'h00);
        check("t6_no_rsp", 64'(rsp_count - base), 64'd0);
        check("t6_req_ready", 64'(core.req_ready), 64'd1);
        check("queue_empty", 64'(exq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
